// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, state codes, ALU classes, mux selects.
// Latency: none (definitions only).
// Backpressure: none (definitions only); ILLEGAL_OP_TRAP_EN adds the TRAP state code.
package mips_ctrl_pkg;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU control classes consumed by the ALU control block
    localparam logic [2:0] ALUOP_NONE = 3'b000;
    localparam logic [2:0] ALUOP_LUI  = 3'b001;
    localparam logic [2:0] ALUOP_ADD  = 3'b010;
    localparam logic [2:0] ALUOP_ANDI = 3'b011;
    localparam logic [2:0] ALUOP_SUB  = 3'b100;
    localparam logic [2:0] ALUOP_ORI  = 3'b101;
    localparam logic [2:0] ALUOP_ADDI = 3'b110;
    localparam logic [2:0] ALUOP_R    = 3'b111;

    // Register destination select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // Register write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // ALU B operand select
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Controller states; the code is also exported on the debug port
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_ALU_WB   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_JAL      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        S_TRAP     = 4'd11
`endif
    } state_t;

    // Control vector for one cycle. fetch_ld marks the FETCH cycle whose
    // IR/PC load is qualified by mem_ready outside the registered vector.
    typedef struct packed {
        logic       fetch_ld;
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // True for the opcodes that go through EXEC / ALU_WB
    function automatic logic is_alu_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_ORI)   || (op == OP_LUI);
    endfunction

    // ALU class used in EXEC for the register/immediate arithmetic group
    function automatic logic [2:0] alu_class(input logic [5:0] op);
        logic [2:0] cls;
        case (op)
            OP_RTYPE: cls = ALUOP_R;
            OP_ADDI:  cls = ALUOP_ADDI;
            OP_ANDI:  cls = ALUOP_ANDI;
            OP_ORI:   cls = ALUOP_ORI;
            OP_LUI:   cls = ALUOP_LUI;
            default:  cls = ALUOP_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-plus-opcode to datapath control-vector decoder.
// Latency: 0 cycles (pure combinational; the top registers the result).
// Backpressure: none; mem_ready qualification is applied by the top.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    output ctrl_t      o_ctrl
);

    logic w_rtype;
    assign w_rtype = (i_op == OP_RTYPE);

    // Moore decode: every field not named for a state stays at 0
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.fetch_ld  = 1'b1;
                o_ctrl.i_or_d    = 1'b0;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMMSH;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = w_rtype ? SRCB_B : SRCB_IMM;
                o_ctrl.alu_op    = alu_class(i_op);
            end
            S_ALU_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
                o_ctrl.reg_dst    = w_rtype ? REGDST_RD : REGDST_RT;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.i_or_d   = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_RT;
                o_ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a   = 1'b1;
                o_ctrl.alu_src_b   = SRCB_B;
                o_ctrl.alu_op      = ALUOP_SUB;
                o_ctrl.pc_source   = PCSRC_ALUOUT;
                o_ctrl.pc_write_eq = (i_op == OP_BEQ);
                o_ctrl.pc_write_ne = (i_op == OP_BNE);
            end
            S_JUMP: begin
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.pc_write  = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so it is the link value
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REGDST_RA;
                o_ctrl.mem_to_reg = M2R_PC;
            end
            default: begin
                // TRAP and unused codes: all strobes low
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: 3-5 cycles per instruction over a shared memory port and ALU.
// Latency: registered Moore outputs; FETCH IR/PC load is qualified by mem_ready in the same cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with strobes stable while mem_ready=0. Macro: ILLEGAL_OP_TRAP_EN.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int RA_INDEX    = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_eq,
    output logic                   pc_write_ne,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic [1:0]             reg_dst,
    output logic [1:0]             mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             pc_source,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic [3:0]             state,
    output logic                   illegal_op
);

    // The datapath hardwires $31 for reg_dst=2 and the ALU classes are 3 bits wide
    if (RA_INDEX != 31 || ALUOP_WIDTH < 3) begin : g_param_check
        $error("multicycle_control: RA_INDEX must be 31 and ALUOP_WIDTH at least 3");
    end

    state_t r_state;
    state_t w_next_state;
    ctrl_t  r_ctrl;
    ctrl_t  w_next_ctrl;
    // Low for the single cycle after reset so FETCH starts with its strobes already registered
    logic   r_run;

    // Next-state selection; op is only looked at once the IR is stable
    always_comb begin
        w_next_state = r_state;
        if (!r_run) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_EXEC;
                        OP_LW, OP_SW:                               w_next_state = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:                             w_next_state = S_BRANCH;
                        OP_J:                                       w_next_state = S_JUMP;
                        OP_JAL:                                     w_next_state = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:                                    w_next_state = S_TRAP;
`else
                        default:                                    w_next_state = S_FETCH;
`endif
                    endcase
                end
                S_EXEC:     w_next_state = S_ALU_WB;
                S_ALU_WB:   w_next_state = S_FETCH;
                S_MEM_ADDR: w_next_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) w_next_state = S_MEM_WB;
                S_MEM_WB:   w_next_state = S_FETCH;
                S_MEM_WR:   if (mem_ready) w_next_state = S_FETCH;
                S_BRANCH:   w_next_state = S_FETCH;
                S_JUMP:     w_next_state = S_FETCH;
                S_JAL:      w_next_state = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                S_TRAP:     w_next_state = S_TRAP;
`endif
                default:    w_next_state = S_FETCH;
            endcase
        end
    end

    // Decode the state being entered so the control vector registers alongside it
    mc_output_decode u_output_decode (
        .i_state (w_next_state),
        .i_op    (op),
        .o_ctrl  (w_next_ctrl)
    );

    // State and registered control vector; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= w_next_ctrl;
            r_run   <= 1'b1;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal_op;

    // Sticky flag raised on entry to TRAP, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_op <= 1'b0;
        end else if (w_next_state == S_TRAP) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign illegal_op = r_illegal_op;
`else
    assign illegal_op = 1'b0;
`endif

    // FETCH loads IR and PC only in the cycle the memory returns the word
    assign ir_write    = r_ctrl.fetch_ld & mem_ready;
    assign pc_write    = r_ctrl.pc_write | (r_ctrl.fetch_ld & mem_ready);
    assign pc_write_eq = r_ctrl.pc_write_eq;
    assign pc_write_ne = r_ctrl.pc_write_ne;
    assign i_or_d      = r_ctrl.i_or_d;
    assign mem_read    = r_ctrl.mem_read;
    assign mem_write   = r_ctrl.mem_write;
    assign reg_dst     = r_ctrl.reg_dst;
    assign mem_to_reg  = r_ctrl.mem_to_reg;
    assign reg_write   = r_ctrl.reg_write;
    assign alu_src_a   = r_ctrl.alu_src_a;
    assign alu_src_b   = r_ctrl.alu_src_b;
    assign pc_source   = r_ctrl.pc_source;
    assign alu_op      = ALUOP_WIDTH'(r_ctrl.alu_op);
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model builds the expected per-cycle control vectors.
// Latency: each instruction is expanded into its cycle list including random memory stalls.
// Backpressure: mem_ready is randomised in memory states and ignored (randomised) elsewhere.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic       reg_write, alu_src_a;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal_op;

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_WIDTH(3), .RA_INDEX(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_write_eq (pc_write_eq),
        .pc_write_ne (pc_write_ne),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_source   (pc_source),
        .alu_op      (alu_op),
        .state       (state),
        .illegal_op  (illegal_op)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } vec_t;

    // One expected cycle: stimulus plus expected outputs. hold: 1 = state must
    // equal last cycle's, 0 = must differ.
    typedef struct {
        logic [5:0] op;
        bit         mr_set;
        bit         mr;
        vec_t       exp;
        int         hold;
        bit         ill;
    } cyc_t;

    cyc_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] prev_state;
    bit         after_reset;
    logic [5:0] legal_ops [11] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                                   6'h04, 6'h05, 6'h02, 6'h03};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t obs();
        vec_t v;
        v.pc_write    = pc_write;
        v.pc_write_eq = pc_write_eq;
        v.pc_write_ne = pc_write_ne;
        v.i_or_d      = i_or_d;
        v.mem_read    = mem_read;
        v.mem_write   = mem_write;
        v.ir_write    = ir_write;
        v.reg_dst     = reg_dst;
        v.mem_to_reg  = mem_to_reg;
        v.reg_write   = reg_write;
        v.alu_src_a   = alu_src_a;
        v.alu_src_b   = alu_src_b;
        v.pc_source   = pc_source;
        v.alu_op      = alu_op;
        return v;
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic [5:0] o, input bit mr_set, input bit mr,
                        input vec_t e, input int hold, input bit ill);
        cyc_t c;
        c.op = o; c.mr_set = mr_set; c.mr = mr; c.exp = e; c.hold = hold; c.ill = ill;
        q.push_back(c);
    endtask

    // Expand one instruction into its expected cycles (fs FETCH stalls, ms memory stalls)
    task automatic build(input logic [5:0] o, input int fs, input int ms);
        vec_t f, v;
        int   h0;
        h0 = after_reset ? 1 : 0;
        after_reset = 1'b0;
        f = '0; f.mem_read = 1'b1; f.alu_src_b = 2'd1; f.alu_op = 3'b010;
        for (int k = 0; k < fs; k++) push(o, 1'b1, 1'b0, f, (k == 0) ? h0 : 1, 1'b0);
        v = f; v.ir_write = 1'b1; v.pc_write = 1'b1;
        push(o, 1'b1, 1'b1, v, (fs == 0) ? h0 : 1, 1'b0);
        v = '0; v.alu_src_b = 2'd3; v.alu_op = 3'b010;
        push(o, 1'b0, 1'b0, v, 0, 1'b0);
        case (o)
            6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = (o == 6'h00) ? 2'd0 : 2'd2;
                v.alu_op = (o == 6'h00) ? 3'b111 : (o == 6'h08) ? 3'b110 :
                           (o == 6'h0C) ? 3'b011 : (o == 6'h0D) ? 3'b101 : 3'b001;
                push(o, 1'b0, 1'b0, v, 0, 1'b0);
                v = '0; v.reg_write = 1'b1; v.reg_dst = (o == 6'h00) ? 2'd1 : 2'd0;
                push(o, 1'b0, 1'b0, v, 0, 1'b0);
            end
            6'h23, 6'h2B: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'd2; v.alu_op = 3'b010;
                push(o, 1'b0, 1'b0, v, 0, 1'b0);
                v = '0; v.i_or_d = 1'b1;
                if (o == 6'h23) v.mem_read = 1'b1; else v.mem_write = 1'b1;
                for (int k = 0; k < ms; k++) push(o, 1'b1, 1'b0, v, (k == 0) ? 0 : 1, 1'b0);
                push(o, 1'b1, 1'b1, v, (ms == 0) ? 0 : 1, 1'b0);
                if (o == 6'h23) begin
                    v = '0; v.reg_write = 1'b1; v.mem_to_reg = 2'd1;
                    push(o, 1'b0, 1'b0, v, 0, 1'b0);
                end
            end
            6'h04, 6'h05: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_op = 3'b100; v.pc_source = 2'd1;
                v.pc_write_eq = (o == 6'h04); v.pc_write_ne = (o == 6'h05);
                push(o, 1'b0, 1'b0, v, 0, 1'b0);
            end
            6'h02: begin
                v = '0; v.pc_source = 2'd2; v.pc_write = 1'b1;
                push(o, 1'b0, 1'b0, v, 0, 1'b0);
            end
            6'h03: begin
                v = '0; v.pc_source = 2'd2; v.pc_write = 1'b1; v.reg_write = 1'b1;
                v.reg_dst = 2'd2; v.mem_to_reg = 2'd2;
                push(o, 1'b0, 1'b0, v, 0, 1'b0);
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                for (int k = 0; k < 4; k++) push(o, 1'b0, 1'b0, '0, (k == 0) ? 0 : 1, 1'b1);
`endif
            end
        endcase
    endtask

    // Drive and check up to maxc queued cycles, then drop the rest
    task automatic run_queue(input int maxc);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0 && n < maxc) begin
            c = q.pop_front();
            @(negedge clk);
            op = c.op;
            mem_ready = c.mr_set ? c.mr : 1'($urandom);
            #1;
            check_eq("ctrl", 32'(obs()), 32'(c.exp));
            check_eq("hold", 32'(state == prev_state), 32'(c.hold));
            check_eq("illegal_op", 32'(illegal_op), 32'(c.ill));
            prev_state = state;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'($urandom);
        @(negedge clk);
        #1;
        check_eq("rst_ctrl", 32'(obs()), 32'd0);
        check_eq("rst_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        check_eq("post_rst_ctrl", 32'(obs()), 32'd0);
        check_eq("post_rst_illegal", 32'(illegal_op), 32'd0);
        prev_state = state;
        after_reset = 1'b1;
    endtask

    task automatic do_instr(input logic [5:0] o, input int fs, input int ms);
        build(o, fs, ms);
        run_queue(1000);
    endtask

    initial begin
        logic [5:0] rop;
        reset = 1'b1;
        op = 6'h00;
        mem_ready = 1'b0;
        prev_state = '0;
        after_reset = 1'b0;
        do_reset();

        // Directed: each opcode class, with and without stalls
        do_instr(6'h00, 0, 0);
        do_instr(6'h23, 0, 3);
        do_instr(6'h2B, 0, 0);
        do_instr(6'h05, 0, 0);
        do_instr(6'h03, 0, 0);
        do_instr(6'h02, 1, 0);
        do_instr(6'h04, 0, 0);
        do_instr(6'h08, 2, 0);
        do_instr(6'h0C, 0, 0);
        do_instr(6'h0D, 0, 0);
        do_instr(6'h0F, 0, 0);
        do_instr(6'h2B, 1, 2);
`ifndef ILLEGAL_OP_TRAP_EN
        do_instr(6'h3F, 0, 0);
`endif

        // Random instruction mix with random stall lengths
        for (int i = 0; i < 150; i++) begin
            rop = legal_ops[$urandom_range(0, 10)];
`ifndef ILLEGAL_OP_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                rop = 6'h3F;
                for (int t = 0; t < 20; t++) begin
                    rop = 6'($urandom_range(0, 63));
                    if (!is_legal(rop)) break;
                end
                if (is_legal(rop)) rop = 6'h3F;
            end
`endif
            do_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while stalled in MEM_RD aborts the load with no writeback
        build(6'h23, 0, 10);
        run_queue(5);
        do_reset();
        do_instr(6'h00, 0, 0);

        // Unknown opcode: NOP, or TRAP until reset when the trap is built in
        do_instr(6'h3F, 0, 0);
        do_reset();
        do_instr(6'h03, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
